pixel_row: RTL and testbench

Behavioural, clocked model of one row of PIXEL_ARRAY_WIDTH image-sensor pixels with per-pixel single-slope ADC storage. The row sits between the sensor state machine, which drives ERASE, EXPOSE, RAMP and READ and supplies the shared 8-bit COUNTER, and the readout logic, which samples DATA_OUT. Each pixel integrates a fixed, pixel-specific light intensity during exposure. During conversion, each pixel latches the COUNTER value at which its ramp crosses the integrated level, then presents the code on READ.

---
 rtl/pixel_pkg.sv | 43 ++++
 rtl/pixel_row_if.sv | 49 ++++
 rtl/pixel_sensor.sv | 90 +++++++++
 rtl/pixel_row.sv | 48 ++++
 tb/tb_pixel_row.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_pkg.sv
// -----------------------------------------------------------------------------
// pixel_pkg
// Shared constants and helpers for the pixel row model.
//   CODE_W          : width of the ADC code / ramp / COUNTER (8)
//   ACC_W           : width of the exposure accumulator (16)
//   LIGHT_BASE_DEF  : default exposure increment of column 0
//   LIGHT_STEP_DEF  : default extra increment per column index
// Helpers:
//   pixel_step()    : per-column exposure increment, truncated to ACC_W bits
//   sat_add()       : saturating accumulator add
//   sat_inc()       : saturating ramp increment
// -----------------------------------------------------------------------------
package pixel_pkg;

   localparam int unsigned CODE_W         = 8;
   localparam int unsigned ACC_W          = 16;
   localparam int unsigned LIGHT_BASE_DEF = 64;
   localparam int unsigned LIGHT_STEP_DEF = 32;

   typedef logic [CODE_W-1:0] code_t;
   typedef logic [ACC_W-1:0]  acc_t;

   // Increment is formed in 32 bits and truncated to the accumulator width.
   function automatic acc_t pixel_step(input int unsigned base,
                                       input int unsigned step,
                                       input int unsigned col);
      int unsigned full;
      full = base + col * step;
      return acc_t'(full);
   endfunction

   // Carry out of the widened sum selects the all-ones clamp.
   function automatic acc_t sat_add(input acc_t a, input acc_t b);
      logic [ACC_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[ACC_W] ? '1 : sum[ACC_W-1:0];
   endfunction

   function automatic code_t sat_inc(input code_t c);
      return (c == '1) ? c : code_t'(c + 1'b1);
   endfunction

endpackage

// File: rtl/pixel_row_if.sv
// -----------------------------------------------------------------------------
// pixel_row_if
// Control/readout bundle between the sensor state machine, the pixel row and
// the readout logic. Signal names match the legacy row ports.
//   VBN1     : exposure bias strobe
//   RAMP     : conversion ramp strobe
//   ERASE    : clear all pixel state
//   EXPOSE   : exposure phase enable
//   READ     : output enable for stored codes
//   COUNTER  : shared 8-bit digital ramp value
//   DATA_OUT : packed per-pixel codes, element i = pixel i
// Modports:
//   master : sequencer/readout side (drives controls, samples DATA_OUT)
//   slave  : pixel row side
// -----------------------------------------------------------------------------
interface pixel_row_if #(
   parameter int unsigned PIXEL_ARRAY_WIDTH = 4
);
   import pixel_pkg::*;

   logic  VBN1;
   logic  RAMP;
   logic  ERASE;
   logic  EXPOSE;
   logic  READ;
   code_t COUNTER;
   logic  [PIXEL_ARRAY_WIDTH-1:0][CODE_W-1:0] DATA_OUT;

   modport master (
      output VBN1,
      output RAMP,
      output ERASE,
      output EXPOSE,
      output READ,
      output COUNTER,
      input  DATA_OUT
   );

   modport slave (
      input  VBN1,
      input  RAMP,
      input  ERASE,
      input  EXPOSE,
      input  READ,
      input  COUNTER,
      output DATA_OUT
   );

endinterface

// File: rtl/pixel_sensor.sv
// -----------------------------------------------------------------------------
// pixel_sensor
// One pixel: saturating exposure accumulator plus single-slope ADC latch.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   erase_i     : clear accumulator, ramp, stored code and latch flag
//   expose_i    : exposure phase enable
//   vbn1_i      : exposure bias strobe (integrates only with expose_i)
//   ramp_i      : conversion strobe, one ramp step per cycle
//   read_i      : output enable for the stored code
//   counter_i   : shared ramp value latched on comparator trip
//   data_o      : stored code when read_i, else zero
// Parameters:
//   COLUMN      : column index, selects the pixel's light intensity
//   LIGHT_BASE  : increment of column 0
//   LIGHT_STEP  : extra increment per column
// -----------------------------------------------------------------------------
module pixel_sensor
   import pixel_pkg::*;
#(
   parameter int unsigned COLUMN     = 0,
   parameter int unsigned LIGHT_BASE = LIGHT_BASE_DEF,
   parameter int unsigned LIGHT_STEP = LIGHT_STEP_DEF
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  erase_i,
   input  logic  expose_i,
   input  logic  vbn1_i,
   input  logic  ramp_i,
   input  logic  read_i,
   input  code_t counter_i,
   output code_t data_o
);

   localparam acc_t STEP = pixel_step(LIGHT_BASE, LIGHT_STEP, COLUMN);

   acc_t  acc_q,  acc_d;
   code_t ramp_q, ramp_d;
   code_t mem_q,  mem_d;
   logic  done_q, done_d;
   code_t level;

   assign level = acc_q[ACC_W-1 -: CODE_W];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q  <= '0;
         ramp_q <= '0;
         mem_q  <= '0;
         done_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         ramp_q <= ramp_d;
         mem_q  <= mem_d;
         done_q <= done_d;
      end
   end

   // Exposure and conversion update disjoint state, so both may act in the
   // same cycle; the comparator always sees the registered (pre-update)
   // level and ramp.
   always_comb begin
      acc_d  = acc_q;
      ramp_d = ramp_q;
      mem_d  = mem_q;
      done_d = done_q;

      if (erase_i) begin
         acc_d  = '0;
         ramp_d = '0;
         mem_d  = '0;
         done_d = 1'b0;
      end else begin
         if (expose_i && vbn1_i) begin
            acc_d = sat_add(acc_q, STEP);
         end
         if (ramp_i) begin
            if (!done_q && (ramp_q >= level)) begin
               mem_d  = counter_i;
               done_d = 1'b1;
            end
            ramp_d = sat_inc(ramp_q);
         end
      end
   end

   assign data_o = read_i ? mem_q : '0;

endmodule

// File: rtl/pixel_row.sv
// -----------------------------------------------------------------------------
// pixel_row
// One row of PIXEL_ARRAY_WIDTH pixels with per-pixel single-slope ADC storage.
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-high reset
//   bus    : pixel_row_if.slave (VBN1, RAMP, ERASE, EXPOSE, READ, COUNTER in;
//            DATA_OUT out, element i = code of pixel i, zero while READ low)
// Parameters:
//   PIXEL_ARRAY_WIDTH : number of columns (must match the interface)
//   LIGHT_BASE        : exposure increment of column 0
//   LIGHT_STEP        : additional increment per column index
// -----------------------------------------------------------------------------
module pixel_row
   import pixel_pkg::*;
#(
   parameter int unsigned PIXEL_ARRAY_WIDTH = 4,
   parameter int unsigned LIGHT_BASE        = LIGHT_BASE_DEF,
   parameter int unsigned LIGHT_STEP        = LIGHT_STEP_DEF
) (
   input logic        clk,
   input logic        reset,
   pixel_row_if.slave bus
);

   logic [PIXEL_ARRAY_WIDTH-1:0][CODE_W-1:0] codes;

   for (genvar gi = 0; gi < PIXEL_ARRAY_WIDTH; gi++) begin : g_pixel
      pixel_sensor #(
         .COLUMN     (gi),
         .LIGHT_BASE (LIGHT_BASE),
         .LIGHT_STEP (LIGHT_STEP)
      ) u_pixel (
         .clk       (clk),
         .reset     (reset),
         .erase_i   (bus.ERASE),
         .expose_i  (bus.EXPOSE),
         .vbn1_i    (bus.VBN1),
         .ramp_i    (bus.RAMP),
         .read_i    (bus.READ),
         .counter_i (bus.COUNTER),
         .data_o    (codes[gi])
      );
   end

   assign bus.DATA_OUT = codes;

endmodule

// File: tb/tb_pixel_row.sv
// -----------------------------------------------------------------------------
// tb_pixel_row
// Self-checking bench for pixel_row. A behavioural model holds each pixel's
// exposure as a plain integer, the ramp position and the latched codes.
// -----------------------------------------------------------------------------
module tb_pixel_row;
   import pixel_pkg::*;

   localparam int W = 4;

   logic clk = 1'b0;
   logic reset;

   pixel_row_if #(.PIXEL_ARRAY_WIDTH(W)) bus ();

   pixel_row #(
      .PIXEL_ARRAY_WIDTH (W),
      .LIGHT_BASE        (64),
      .LIGHT_STEP        (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state
   int m_acc [W];
   int m_ramp;
   int m_mem [W];
   bit m_done[W];

   function automatic int step_of(input int i);
      return 64 + i * 32;
   endfunction

   function automatic int exp_code(input int i);
      return bus.READ ? m_mem[i] : 0;
   endfunction

   function void model_clear();
      for (int i = 0; i < W; i++) begin
         m_acc[i]  = 0;
         m_mem[i]  = 0;
         m_done[i] = 1'b0;
      end
      m_ramp = 0;
   endfunction

   // Apply one clock of inputs and advance the model. Returns at posedge+1.
   task automatic cycle(input bit erase, input bit expose, input bit vbn1,
                        input bit ramp, input int counter);
      bus.ERASE   = erase;
      bus.EXPOSE  = expose;
      bus.VBN1    = vbn1;
      bus.RAMP    = ramp;
      bus.COUNTER = 8'(counter);
      @(posedge clk);
      #1;
      if (erase) begin
         model_clear();
      end else begin
         if (ramp) begin
            for (int i = 0; i < W; i++) begin
               if (!m_done[i] && m_ramp >= m_acc[i] / 256) begin
                  m_mem[i]  = counter & 255;
                  m_done[i] = 1'b1;
               end
            end
            if (m_ramp < 255) m_ramp = m_ramp + 1;
         end
         if (expose && vbn1) begin
            for (int i = 0; i < W; i++) begin
               m_acc[i] = m_acc[i] + step_of(i);
               if (m_acc[i] > 65535) m_acc[i] = 65535;
            end
         end
      end
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 0);
   endtask

   // Erase 5 cycles, n_exp exposure cycles, n_ramp ramp cycles with COUNTER=k.
   task automatic frame(input int n_exp, input int n_ramp);
      for (int c = 0; c < 5; c++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
      for (int c = 0; c < n_exp; c++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 0);
      for (int k = 0; k < n_ramp; k++) cycle(1'b0, 1'b0, 1'b0, 1'b1, k);
      idle();
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      bus.ERASE   = 1'($urandom);
      bus.EXPOSE  = 1'($urandom);
      bus.VBN1    = 1'($urandom);
      bus.RAMP    = 1'($urandom);
      bus.READ    = 1'b1;
      bus.COUNTER = 8'($urandom);
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < W; i++) begin
         n_tests++;
         if (bus.DATA_OUT[i] !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_hold pix%0d: got %0d want 0", i, bus.DATA_OUT[i]);
         end
      end
      reset = 1'b0;
      idle();
      bus.READ = 1'b1;
      #1;
      for (int i = 0; i < W; i++) begin
         n_tests++;
         if (bus.DATA_OUT[i] !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_release pix%0d: got %0d want 0", i, bus.DATA_OUT[i]);
         end
      end
   endtask

   task automatic test_nominal();
      int want[W];
      want = '{63, 95, 127, 159};
      bus.READ = 1'b0;
      frame(255, 255);
      bus.READ = 1'b1;
      #1;
      for (int i = 0; i < W; i++) begin
         n_tests++;
         if (bus.DATA_OUT[i] !== 8'(want[i]) || m_mem[i] != want[i]) begin
            n_fail++;
            $display("FAIL nominal pix%0d: got %0d want %0d (model %0d)",
                     i, bus.DATA_OUT[i], want[i], m_mem[i]);
         end
      end
   endtask

   task automatic test_read_low();
      bus.READ = 1'b0;
      frame(255, 255);
      for (int i = 0; i < W; i++) begin
         n_tests++;
         if (bus.DATA_OUT[i] !== 8'd0) begin
            n_fail++;
            $display("FAIL read_low pix%0d: got %0d want 0", i, bus.DATA_OUT[i]);
         end
      end
      // READ is combinational: raise it between edges and look right away.
      #2 bus.READ = 1'b1;
      #1;
      for (int i = 0; i < W; i++) begin
         n_tests++;
         if (bus.DATA_OUT[i] !== 8'(exp_code(i))) begin
            n_fail++;
            $display("FAIL read_rise pix%0d: got %0d want %0d", i, bus.DATA_OUT[i], exp_code(i));
         end
      end
      bus.READ = 1'b0;
   endtask

   task automatic test_saturation();
      bus.READ = 1'b1;
      frame(2000, 256);
      for (int i = 0; i < W; i++) begin
         n_tests++;
         if (bus.DATA_OUT[i] !== 8'd255 || m_mem[i] != 255) begin
            n_fail++;
            $display("FAIL sat_256 pix%0d: got %0d want 255", i, bus.DATA_OUT[i]);
         end
      end
      frame(2000, 200);
      for (int i = 0; i < W; i++) begin
         n_tests++;
         if (bus.DATA_OUT[i] !== 8'd0) begin
            n_fail++;
            $display("FAIL sat_200 pix%0d: got %0d want 0", i, bus.DATA_OUT[i]);
         end
      end
   endtask

   task automatic test_erase_mid();
      int want[W];
      want = '{63, 95, 127, 159};
      bus.READ = 1'b1;
      // 64 ramp cycles: only pixel 0 (level 63) has tripped.
      frame(255, 64);
      for (int i = 0; i < W; i++) begin
         n_tests++;
         if (bus.DATA_OUT[i] !== 8'(exp_code(i))) begin
            n_fail++;
            $display("FAIL part_conv pix%0d: got %0d want %0d", i, bus.DATA_OUT[i], exp_code(i));
         end
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 99);
      for (int i = 0; i < W; i++) begin
         n_tests++;
         if (bus.DATA_OUT[i] !== 8'd0) begin
            n_fail++;
            $display("FAIL erase_mid pix%0d: got %0d want 0", i, bus.DATA_OUT[i]);
         end
      end
      frame(255, 255);
      for (int i = 0; i < W; i++) begin
         n_tests++;
         if (bus.DATA_OUT[i] !== 8'(want[i])) begin
            n_fail++;
            $display("FAIL reframe pix%0d: got %0d want %0d", i, bus.DATA_OUT[i], want[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bus.READ = 1'b1;
      frame(255, 100);
      n_tests++;
      if (bus.DATA_OUT[0] !== 8'd63) begin
         n_fail++;
         $display("FAIL pre_reset pix0: got %0d want 63", bus.DATA_OUT[0]);
      end
      #2 reset = 1'b1;
      #1;
      model_clear();
      for (int i = 0; i < W; i++) begin
         n_tests++;
         if (bus.DATA_OUT[i] !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset pix%0d: got %0d want 0", i, bus.DATA_OUT[i]);
         end
      end
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_no_vbn1();
      bus.READ = 1'b1;
      for (int c = 0; c < 5; c++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 0);
      for (int c = 0; c < 255; c++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 7);
      for (int i = 0; i < W; i++) begin
         n_tests++;
         if (bus.DATA_OUT[i] !== 8'd7) begin
            n_fail++;
            $display("FAIL no_vbn1 pix%0d: got %0d want 7", i, bus.DATA_OUT[i]);
         end
      end
   endtask

   // Random frames: gated exposure, overlapping ramp/exposure, random COUNTER
   // and READ, checked against the model after every conversion cycle.
   task automatic test_random();
      for (int f = 0; f < 8; f++) begin
         int n_exp;
         int n_ramp;
         n_exp  = int'($urandom_range(0, 600));
         n_ramp = int'($urandom_range(0, 300));
         for (int c = 0; c < int'($urandom_range(1, 3)); c++)
            cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)));
         for (int c = 0; c < n_exp; c++)
            cycle(1'b0, 1'b1, ($urandom_range(0, 3) != 0), 1'b0, 0);
         for (int c = 0; c < n_ramp; c++) begin
            bus.READ = 1'($urandom);
            cycle(1'b0, ($urandom_range(0, 3) == 0), 1'($urandom), 1'b1,
                  int'($urandom_range(0, 255)));
            for (int i = 0; i < W; i++) begin
               n_tests++;
               if (bus.DATA_OUT[i] !== 8'(exp_code(i))) begin
                  n_fail++;
                  $display("FAIL random f%0d c%0d pix%0d: got %0d want %0d",
                           f, c, i, bus.DATA_OUT[i], exp_code(i));
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_read_low();
      test_saturation();
      test_erase_mid();
      test_reset_mid();
      test_no_vbn1();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
